// File: rtl/wb_manager_if.sv
// Client command/response channel and Wishbone manager port of wb_manager.
// master is the wb_manager view; slave is the client/arbitrator view.
interface wb_manager_if;
   localparam int unsigned ADR_W = 32;
   localparam int unsigned DAT_W = 32;
   localparam int unsigned SEL_W = 4;

   logic             cmd_valid_i;
   logic             cmd_ready_o;
   logic             cmd_we_i;
   logic [ADR_W-1:0] cmd_adr_i;
   logic [DAT_W-1:0] cmd_dat_i;
   logic [SEL_W-1:0] cmd_sel_i;

   logic             rsp_valid_o;
   logic             rsp_ready_i;
   logic [DAT_W-1:0] rsp_dat_o;
   logic             rsp_err_o;

   logic [ADR_W-1:0] wbm_adr_o;
   logic [DAT_W-1:0] wbm_dat_o;
   logic [SEL_W-1:0] wbm_sel_o;
   logic             wbm_we_o;
   logic             wbm_stb_o;
   logic             wbm_cyc_o;
   logic [DAT_W-1:0] wbm_dat_i;
   logic             wbm_ack_i;

   modport master (
      input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
      input  rsp_ready_i, wbm_dat_i, wbm_ack_i,
      output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
      output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o, wbm_cyc_o
   );

   modport slave (
      output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
      output rsp_ready_i, wbm_dat_i, wbm_ack_i,
      input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
      input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o, wbm_cyc_o
   );
endinterface

// File: rtl/wb_manager.sv
// Single-outstanding Wishbone manager: turns one client command into one bus
// cycle with an ack timeout, then holds the response until the client takes it.
module wb_manager #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   wb_manager_if.master  bus
);
   localparam int unsigned ADR_W = 32;
   localparam int unsigned DAT_W = 32;
   localparam int unsigned SEL_W = 4;
   localparam int unsigned TMR_W = 8;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
   logic             rsp_err_q, rsp_err_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic [DAT_W-1:0] dat_q, dat_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             we_q, we_d;
   logic             cyc_q, cyc_d;

   // State and registered outputs
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         we_q        <= 1'b0;
         cyc_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         we_q        <= we_d;
         cyc_q       <= cyc_d;
      end
   end

   // Next state and next output values
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      we_d        = we_q;
      cyc_d       = cyc_q;

      unique case (state_q)
         IDLE: begin
            // ready_q gates acceptance so the first cycle after reset is not taken
            if (cmd_ready_q && bus.cmd_valid_i) begin
               state_d     = BUS;
               timer_d     = '0;
               cmd_ready_d = 1'b0;
               cyc_d       = 1'b1;
               we_d        = bus.cmd_we_i;
               adr_d       = bus.cmd_adr_i;
               dat_d       = bus.cmd_we_i ? bus.cmd_dat_i : '0;
               sel_d       = bus.cmd_sel_i;
            end else begin
               cmd_ready_d = 1'b1;
            end
         end
         BUS: begin
            if (bus.wbm_ack_i || (timer_q == TMR_LAST)) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = !bus.wbm_ack_i;
               rsp_dat_d   = (bus.wbm_ack_i && !we_q) ? bus.wbm_dat_i : '0;
               cyc_d       = 1'b0;
               we_d        = 1'b0;
               adr_d       = '0;
               dat_d       = '0;
               sel_d       = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         RESP: begin
            if (bus.rsp_ready_i) begin
               state_d     = IDLE;
               cmd_ready_d = 1'b1;
               rsp_valid_d = 1'b0;
               rsp_dat_d   = '0;
               rsp_err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.cmd_ready_o = cmd_ready_q;
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_dat_o   = rsp_dat_q;
   assign bus.rsp_err_o   = rsp_err_q;
   assign bus.wbm_adr_o   = adr_q;
   assign bus.wbm_dat_o   = dat_q;
   assign bus.wbm_sel_o   = sel_q;
   assign bus.wbm_we_o    = we_q;
   assign bus.wbm_stb_o   = cyc_q;
   assign bus.wbm_cyc_o   = cyc_q;
endmodule
